// File: rtl/pwr_seq_pkg.sv
// pwr_seq_pkg: shared states, mode codes and enable-pattern helper for the power sequencer
package pwr_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic MODE_RAMP = 1'b0;
    localparam logic MODE_WALK = 1'b1;
    localparam int MAX_MODULES = 32;
    localparam int K_W = 6;
    localparam int P_W = MAX_MODULES + 1;
    function automatic logic [MAX_MODULES-1:0] pwr_pattern(input logic m, input logic [K_W-1:0] k);
        logic [P_W-1:0] one;
        one = P_W'(1) << k;
        return (m == MODE_WALK) ? one[MAX_MODULES-1:0] : one[MAX_MODULES-1:0] - 1'b1;
    endfunction
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: loadable down-counter that flags the last cycle of a dwell period
module dwell_timer #(
    parameter int DWELL_W = 32
) (
    input  logic               clk100m,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               en,
    output logic               expire
);
    logic [DWELL_W-1:0] cnt;
    assign expire = en && cnt == '0;
    // count down to zero and park there; a load always wins
    always_ff @(posedge clk100m) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/pwr_seq_ctrl.sv
// pwr_seq_ctrl: steps the DUT power-enable bus through a ramp or walk with a fixed dwell per step
module pwr_seq_ctrl
    import pwr_seq_pkg::*;
#(
    parameter int NUM_MODULES = 32,
    parameter int DWELL_W     = 32,
    parameter int IDX_W       = $clog2(NUM_MODULES + 1)
) (
    input  logic                   clk100m,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   mode,
    input  logic [DWELL_W-1:0]     dwell_cycles,
    output logic [NUM_MODULES-1:0] pwr_en_out,
    output logic [IDX_W-1:0]       step_idx,
    output logic                   step_strobe,
    output logic                   busy,
    output logic                   done
);
    state_t state, state_n;
    logic mode_q, mode_n;
    logic [DWELL_W-1:0] dly_q, dly_n, dly_in;
    logic [IDX_W-1:0] idx_n, idx_inc;
    logic [NUM_MODULES-1:0] en_n;
    logic strobe_n, busy_n, done_n, load, expire, last_step;
    logic [MAX_MODULES-1:0] pat_first, pat_next;
    assign dly_in    = (dwell_cycles == '0) ? '0 : dwell_cycles - 1'b1;
    assign idx_inc   = step_idx + 1'b1;
    assign last_step = step_idx == ((mode_q == MODE_RAMP) ? IDX_W'(NUM_MODULES) : IDX_W'(NUM_MODULES - 1));
    assign pat_first = pwr_pattern(mode, '0);
    assign pat_next  = pwr_pattern(mode_q, K_W'(idx_inc));
    dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk100m  (clk100m),
        .rst      (rst),
        .load     (load),
        .load_val (dly_n),
        .en       (state == RUN),
        .expire   (expire)
    );
    // state and every output are registered together
    always_ff @(posedge clk100m) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= MODE_RAMP;
            dly_q       <= '0;
            step_idx    <= '0;
            pwr_en_out  <= '0;
            step_strobe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            mode_q      <= mode_n;
            dly_q       <= dly_n;
            step_idx    <= idx_n;
            pwr_en_out  <= en_n;
            step_strobe <= strobe_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end
    // next state and outputs: stop beats start, start is ignored while running
    always_comb begin
        state_n  = state;
        mode_n   = mode_q;
        dly_n    = dly_q;
        idx_n    = step_idx;
        en_n     = pwr_en_out;
        strobe_n = 1'b0;
        busy_n   = busy;
        done_n   = done;
        load     = 1'b0;
        if (stop) begin
            state_n = IDLE;
            idx_n   = '0;
            en_n    = '0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end else if (start && state != RUN) begin
            state_n  = RUN;
            mode_n   = mode;
            dly_n    = dly_in;
            idx_n    = '0;
            en_n     = pat_first[NUM_MODULES-1:0];
            strobe_n = 1'b1;
            busy_n   = 1'b1;
            done_n   = 1'b0;
            load     = 1'b1;
        end else if (state == RUN && expire) begin
            if (last_step) begin
                state_n = DONE;
                en_n    = '0;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end else begin
                idx_n    = idx_inc;
                en_n     = pat_next[NUM_MODULES-1:0];
                strobe_n = 1'b1;
                load     = 1'b1;
            end
        end
    end
endmodule

// File: doc/pwr_seq_ctrl.md
# pwr_seq_ctrl

Power-enable sequencer that drives the per-module `pwr_en_in` bus of the power-estimation DUT array. Once started, it steps through a fixed sequence of enable patterns and holds each one for a programmable dwell time. The sequence is either a cumulative ramp or a one-hot walk. It emits a strobe on every pattern change so the measurement logger can timestamp power samples against the number of active modules.

## Interface
- `NUM_MODULES`, default 32: width of the enable bus and number of DUT instances (2..32).
- `DWELL_W`, default 32: width of the dwell-cycle count.
- `IDX_W`, default `$clog2(NUM_MODULES+1)`: width of the step index (6 when `NUM_MODULES`=32).
- `clk100m` input 1: system clock, 100 MHz.
- `rst` input 1: one clock, all logic synchronous to `clk100m`; reset is synchronous and active-high.
- `start` input 1: single-cycle request to begin a sequence.
- `stop` input 1: abort request.
- `mode` input 1: sequence type, sampled at start. 0 = ramp, 1 = walk.
- `dwell_cycles` input DWELL_W: cycles per step, sampled at start.
- `pwr_en_out` output NUM_MODULES: registered enable pattern, goes to the DUT array.
- `step_idx` output IDX_W: index of the current step.
- `step_strobe` output 1: one-cycle pulse on the first cycle of every step.
- `busy` output 1: high while a sequence is running.
- `done` output 1: high after a sequence completes normally; held until the next start or reset.

## Operation
- States:
  - IDLE: reset state.
  - RUN: a sequence is in progress.
  - DONE: entered on normal completion.
- Pattern for step k:
  - Ramp: `(1<<k)-1`, for k = 0..NUM_MODULES, giving NUM_MODULES+1 steps. k=0 is the all-off baseline; the last step is all ones.
  - Walk: `1<<k`, for k = 0..NUM_MODULES-1, giving NUM_MODULES steps.
- Effective dwell is `max(dwell_cycles,1)`. A value of 0 is treated as 1.
- IDLE/DONE to RUN: on `start` with `stop` low.
  - Latch `mode` and the effective dwell.
  - Set step_idx=0 and drive pattern(0).
  - Pulse `step_strobe`, set `busy`=1, clear `done`.
- RUN, dwell counter not expired: hold the current pattern.
- RUN, dwell expired, not the last step: increment step_idx, drive the new pattern, pulse `step_strobe`.
- RUN, dwell expired on the last step: go to DONE with `pwr_en_out`=0, `busy`=0, `done`=1. step_idx keeps its last value.
- `stop` in any state: go to IDLE with `pwr_en_out`=0, `busy`=0, `done`=0, step_idx=0. No strobe.
- `start` and `stop` in the same cycle: `stop` wins.
- `start` while in RUN: ignored. The sequence is not restarted.
- Input changes to `mode` or `dwell_cycles` during RUN have no effect.

## Timing
- All outputs are registered.
- Reset values: `pwr_en_out`=0, `step_idx`=0, `step_strobe`=0, `busy`=0, `done`=0, state=IDLE.
- `start` high in cycle T produces pattern(0), `step_strobe`=1 and `busy`=1 in cycle T+1.
- Every step lasts exactly D = effective dwell cycles. Step k occupies cycles T+1+kD through T+(k+1)D.
- Total RUN length is S·D cycles, where S is the step count.
- Completion: `done`=1 and `pwr_en_out`=0 in cycle T+1+S·D.
- `stop` high in cycle U: outputs are in the abort state in cycle U+1.
- Dwell counter width is DWELL_W. It loads D-1 and counts down to 0; it never wraps.
- Reset asserted mid-sequence takes effect on the next edge and overrides everything else, identical to stop.
- The enable pattern changes only on step boundaries, so the DUT array sees glitch-free enables.

## Structure
- Package `pwr_seq_pkg`:
  - State enum (IDLE, RUN, DONE).
  - Mode constants MODE_RAMP=0 and MODE_WALK=1.
  - A pattern function `pwr_pattern(mode, k)` returning a NUM_MODULES-bit vector.
- Sub-module `dwell_timer`:
  - Inputs: load, load value, enable.
  - Output: single-cycle `expire`.
  - The FSM and step counter live in `pwr_seq_ctrl`.

## Test plan
- Ramp, N=32, dwell=4, start at T:
  - `pwr_en_out` = 0x0, 0x1, 0x3, …, 0xFFFFFFFF, each held 4 cycles.
  - 33 strobes.
  - `done`=1 and output 0 at T+133.
- Walk, N=32, dwell=1:
  - Output goes 0x1, 0x2, …, 0x80000000 on consecutive cycles; strobe high every cycle.
  - `done` at T+33.
- dwell=0 behaves identically to dwell=1.
  - Changing `dwell_cycles` to 100 mid-run has no effect.
- Ramp, dwell=10, `stop` at step 5 cycle 3:
  - Next cycle: output 0, `busy`=0, `done`=0, step_idx=0.
  - A following `start` restarts from step 0.
- `start` and `stop` together from IDLE: remains IDLE.
  - `start` pulsed during RUN: sequence length unchanged.
- `rst` asserted mid-walk at step 7: next cycle all outputs 0.
  - Deassert `rst` and pulse `start`: a full walk completes normally.
